// File: rtl/sim_run_pkg.sv
// sim_run_pkg: shared state and verdict encodings for the simulation run controller.
package sim_run_pkg;

    localparam int FAIL_CODE_W = 2;

    typedef enum logic [1:0] {HOLD, RUN, PASS, FAIL} state_e;

    typedef enum logic [FAIL_CODE_W-1:0] {NONE, DUT, TIMEOUT, WDOG} fail_code_e;

endpackage

// File: rtl/sim_run_wdog.sv
// sim_run_wdog: kickable down-counter that flags a stall after WDOG_CYCLES idle cycles.
// WDOG_CYCLES = 0 disables it; the counter reloads whenever it is not enabled.
module sim_run_wdog #(
    parameter int WDOG_CYCLES = 0,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic kick,
    output logic expire
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(WDOG_CYCLES == 0 ? 0 : WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (!en || kick) ? LOAD : (cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= LOAD;
        else       cnt_q <= cnt_d;
    end

    assign expire = (WDOG_CYCLES != 0) && en && !kick && (cnt_q == '0);

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: holds the DUT in reset, counts run cycles and latches one sticky verdict.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int WDOG_CYCLES  = 0,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dut_passed,
    input  logic                   dut_failed,
    input  logic                   dut_progress,
    output logic                   dut_reset,
    output logic [CNT_W-1:0]       cyc_cnt,
    output logic                   passed,
    output logic                   failed,
    output logic                   done,
    output logic [FAIL_CODE_W-1:0] fail_code
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

    state_e           state_q, state_d;
    fail_code_e       code_q, code_d;
    logic [CNT_W-1:0] hold_q, hold_d, cyc_q, cyc_d;
    logic             expire;

    sim_run_wdog #(.WDOG_CYCLES(WDOG_CYCLES), .CNT_W(CNT_W)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q == RUN),
        .kick   (dut_progress),
        .expire (expire)
    );

    // Verdict priority: DUT fail, DUT pass, watchdog stall, timeout.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                    cyc_d   = CNT_W'(1);
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (dut_failed) begin
                    state_d = FAIL;
                    code_d  = DUT;
                end else if (dut_passed) begin
                    state_d = PASS;
                end else if (expire) begin
                    state_d = FAIL;
                    code_d  = WDOG;
                end else if (cyc_q == MAX_CNT) begin
                    state_d = FAIL;
                    code_d  = TIMEOUT;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
            code_q  <= NONE;
            hold_q  <= HOLD_LOAD;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
        end
    end

    assign dut_reset = (state_q == HOLD);
    assign cyc_cnt   = cyc_q;
    assign passed    = (state_q == PASS);
    assign failed    = (state_q == FAIL);
    assign done      = passed | failed;
    assign fail_code = code_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed and random runs checked every cycle against a run-count model.
module tb_sim_run_ctrl;

    localparam int R = 4, MAX = 50, W = 8, CW = 16;

    logic          clk = 0, reset = 1, dp = 0, df = 0, dg = 0;
    logic          dut_reset, passed, failed, done;
    logic [CW-1:0] cyc_cnt;
    logic [1:0]    fail_code;

    always #5 clk = ~clk;

    sim_run_ctrl #(.RESET_CYCLES(R), .MAX_CYCLES(MAX), .WDOG_CYCLES(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .dut_passed   (dp),
        .dut_failed   (df),
        .dut_progress (dg),
        .dut_reset    (dut_reset),
        .cyc_cnt      (cyc_cnt),
        .passed       (passed),
        .failed       (failed),
        .done         (done),
        .fail_code    (fail_code)
    );

    int checks = 0, errors = 0;
    // mk: reset-low edges seen since reset; mv: 0 none, 1 pass, 2 fail; mc: code; mlp: last progress run cycle
    int mk = 0, mv = 0, mc = 0, mlp = 0, t = 0;
    bit valid = 0;
    logic hist_rst[256];
    logic hist_done[256];
    int   hist_cyc[256];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, got, exp, t);
        end
    endtask

    function automatic int mhold();
        return (mv == 0 && mk < R) ? 1 : 0;
    endfunction

    function automatic int mcyc();
        return mhold() != 0 ? 0 : mk - R + 1;
    endfunction

    task automatic mstep();
        int n;
        if (reset) begin
            mk = 0; mv = 0; mc = 0; mlp = 0; valid = 1;
        end else if (mv != 0) begin
        end else if (mk < R) begin
            mk++; mlp = 0;
        end else begin
            n = mk - R + 1;
            if (df) begin mv = 2; mc = 1; end
            else if (dp) mv = 1;
            else if (W != 0 && !dg && n - mlp == W) begin mv = 2; mc = 3; end
            else if (n == MAX) begin mv = 2; mc = 2; end
            else begin
                if (dg) mlp = n;
                mk++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mstep();
        @(negedge clk);
        if (valid) begin
            chk("dut_reset", int'(dut_reset), mhold());
            chk("cyc_cnt", int'(cyc_cnt), mcyc());
            chk("passed", int'(passed), int'(mv == 1));
            chk("failed", int'(failed), int'(mv == 2));
            chk("done", int'(done), int'(mv != 0));
            chk("fail_code", int'(fail_code), mc);
        end
        if (t < 256) begin
            hist_rst[t]  = dut_reset;
            hist_done[t] = done;
            hist_cyc[t]  = int'(cyc_cnt);
        end
        t++;
    endtask

    task automatic go(input int pass_at, input int fail_at, input int per, input int ph,
                      input int last, input int rst_at, input bit rnd, input int ncyc);
        bit rdone = 0;
        int n;
        bit run;
        t = 0; reset = 1; dp = 0; df = 0; dg = 0;
        tick(); tick();
        reset = 0;
        for (int i = 0; i < ncyc; i++) begin
            run = (mv == 0 && mk >= R);
            n = mk - R + 1;
            reset = 0;
            if (!run || rnd) begin
                dp = 1'($urandom % 2); df = 1'($urandom % 2); dg = 1'($urandom % 2);
            end
            if (rnd) begin
                if (run) begin
                    dp = ($urandom % 40 == 0); df = ($urandom % 70 == 0); dg = ($urandom % 4 == 0);
                end
                reset = ($urandom % 120 == 0);
            end else if (run) begin
                dp = (n == pass_at);
                df = (n == fail_at);
                dg = (per != 0 && n % per == ph && n <= last);
                if (n == rst_at && !rdone) begin reset = 1; rdone = 1; end
            end
            tick();
        end
    endtask

    initial begin
        go(10, -1, 5, 0, 1000, -1, 0, 40);
        chk("A_rst_in_reset", int'(hist_rst[1]), 1);
        chk("A_rst_last_hold", int'(hist_rst[4]), 1);
        chk("A_rst_run", int'(hist_rst[5]), 0);
        chk("A_cyc_hold", hist_cyc[4], 0);
        chk("A_cyc_first", hist_cyc[5], 1);
        chk("A_cyc_second", hist_cyc[6], 2);
        chk("A_cyc_frozen", int'(cyc_cnt), 10);
        chk("A_passed", int'(passed), 1);
        chk("A_code", int'(fail_code), 0);

        go(5, 5, 5, 0, 1000, -1, 0, 30);
        chk("B_failed", int'(failed), 1);
        chk("B_passed", int'(passed), 0);
        chk("B_code", int'(fail_code), 1);
        chk("B_cyc", int'(cyc_cnt), 5);

        go(-1, -1, 5, 0, 1000, -1, 0, 70);
        chk("C_failed", int'(failed), 1);
        chk("C_code", int'(fail_code), 2);
        chk("C_cyc", int'(cyc_cnt), 50);

        go(50, -1, 5, 0, 1000, -1, 0, 70);
        chk("D_done_cleared", int'(hist_done[0]), 0);
        chk("D_passed", int'(passed), 1);
        chk("D_cyc", int'(cyc_cnt), 50);

        go(-1, -1, 7, 6, 20, -1, 0, 45);
        chk("E_failed", int'(failed), 1);
        chk("E_code", int'(fail_code), 3);
        chk("E_cyc", int'(cyc_cnt), 28);

        go(-1, -1, 5, 0, 1000, 30, 0, 105);
        chk("F_pre_reset_cyc", hist_cyc[34], 30);
        chk("F_reset_rst", int'(hist_rst[35]), 1);
        chk("F_reset_cyc", hist_cyc[35], 0);
        chk("F_rehold", int'(hist_rst[38]), 1);
        chk("F_rerun_cyc", hist_cyc[39], 1);
        chk("F_code", int'(fail_code), 2);
        chk("F_cyc", int'(cyc_cnt), 50);

        go(-1, -1, 0, 0, 0, -1, 1, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
